mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive dbg-loss cycles before dbg is forced to win.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single system clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  cpu_req  in  1  CPU access request; held until granted.
  cpu_we  in  1  1 = write, 0 = read.
  cpu_addr  in  32  CPU word address.
  cpu_wdata  in  32  CPU write data.
  cpu_gnt  out  1  CPU request accepted this cycle.
  cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
  cpu_rdata  out  32  CPU read data, held until next CPU read completes.
  dbg_req  in  1  display/debug read request (read-only port); held until granted.
  dbg_addr  in  32  debug word address.
  dbg_gnt  out  1  debug request accepted this cycle.
  dbg_rvalid  out  1  one-cycle pulse: dbg_rdata valid.
  dbg_rdata  out  32  debug read data, held until next debug read completes.
  mem_we  out  1  memory write enable.
  mem_addr  out  32  memory address.
  mem_wdata  out  32  memory write data.
  mem_rdata  in  32  memory read data, valid one cycle after address.
  owner  out  2  last-grant state, for LCD/debug display.

Function
REQ-003 SHALL arbitrate combinationally each cycle; exactly one of cpu_gnt/dbg_gnt high when any request is present, neither otherwise.
REQ-004 SHALL grant CPU when both request, unless starve_cnt == STARVE_MAX, in which case dbg wins that cycle.
REQ-005 SHALL drive mem_addr/mem_we/mem_wdata from the granted port in the grant cycle; mem_we = cpu_we & cpu_gnt; dbg grants force mem_we = 0, mem_wdata = 0.
REQ-006 With no grant, SHALL drive mem_we = 0 and hold mem_addr at its last granted value.
REQ-007 Read granted in cycle N: SHALL register mem_rdata at end of N+1 into that port's rdata and pulse its rvalid in N+2 (fixed latency 2).
REQ-008 SHALL accept back-to-back grants every cycle, tracking in-flight reads with a 2-stage per-port pending pipeline; rvalid order equals grant order.
REQ-009 CPU writes SHALL produce no rvalid.
REQ-010 starve_cnt (3 bits min.) SHALL increment when dbg_req=1 and cpu wins, clear when dbg wins or dbg_req=0, saturate at STARVE_MAX.
REQ-011 owner FSM: IDLE(00) -> CPU(01) on cpu_gnt, -> DBG(10) on dbg_gnt, -> IDLE when no grant; any state reaches any state in one cycle; 11 unreachable, recovers to IDLE.
REQ-012 SHALL not re-grant a port whose request was dropped before grant; requests are not queued internally.

Reset
REQ-013 With rst=1 at a clock edge: owner=IDLE, starve_cnt=0, pending pipelines cleared, cpu_rdata=dbg_rdata=0, mem_addr=0.
REQ-014 During rst, gnt, rvalid and mem_we SHALL be 0 regardless of requests; reads in flight when rst asserts SHALL never raise rvalid.
REQ-015 First grant possible in the cycle after rst deasserts.

Structure
REQ-016 STARVE_MAX default, owner encodings (IDLE/CPU/DBG) and 32-bit address/data widths SHALL live in the shared package.
REQ-017 Starvation counter SHALL be a sub-module, starve_counter (inputs: inc, clr; output: sat).

Verification
REQ-018 CPU read addr 0x10, mem returns 0x8C010004 -> cpu_gnt cycle N, cpu_rvalid N+2, cpu_rdata=0x8C010004; dbg outputs idle.
REQ-019 CPU write addr 0x20 data 0xDEADBEEF -> mem_we=1 same cycle, mem_addr=0x20, no cpu_rvalid.
REQ-020 Both request continuously, STARVE_MAX=4 -> cpu wins 4 cycles, dbg wins 5th, pattern repeats; starve_cnt 0..4.
REQ-021 Alternating grants cpu@0x04, dbg@0x08, cpu@0x0C back-to-back -> rvalids at N+2, N+3, N+4 with correct data per port.
REQ-022 rst asserted one cycle after a dbg read grant -> dbg_rvalid never pulses, dbg_rdata=0, owner=IDLE.
REQ-023 dbg_req dropped after 3 losing cycles, then reasserted -> starve_cnt restarts at 0; CPU keeps priority.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the bus widths, the default starvation limit, the owner-state
// encoding shown on the LCD/debug display, and the counter-width helper.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Last-grant indicator; 2'b11 is never entered on purpose.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

  // Starvation counter width: large enough for max, never below 3 bits.
  function automatic int unsigned cnt_width(input int unsigned max);
    int unsigned w;
    w = $clog2(max + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// starve_counter: counts consecutive cycles the debug port lost arbitration.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : debug requested and CPU won this cycle
//   clr      : debug won or debug is not requesting (takes priority)
//   sat      : count has reached MAX; debug must win this cycle
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = cnt_width(MAX);

  logic [CNT_W-1:0] cnt_q;

  // Saturating loss counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(MAX))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sat = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory port between a CPU
// (read/write) and a display/debug reader (read-only).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             : CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata    : CPU grant, read-return pulse, data
//   dbg_req/addr                      : debug read request, held until dbg_gnt
//   dbg_gnt, dbg_rvalid, dbg_rdata    : debug grant, read-return pulse, data
//   mem_we/addr/wdata, mem_rdata      : memory port (read data one cycle late)
//   owner                             : last-grant state for display
// CPU has priority; the debug port is forced through after STARVE_MAX
// consecutive losses. Read data returns two cycles after the grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  logic              starve_sat;
  logic [ADDR_W-1:0] last_addr_q;
  logic              cpu_rd_p1_q, cpu_rv_q;
  logic              dbg_rd_p1_q, dbg_rv_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  owner_e            state_q, state_d;

  // Combinational arbitration; nothing is granted while in reset.
  assign cpu_gnt = ~rst & cpu_req & ~(dbg_req & starve_sat);
  assign dbg_gnt = ~rst & dbg_req & (~cpu_req | starve_sat);

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (dbg_req & cpu_gnt),
    .clr (dbg_gnt | ~dbg_req),
    .sat (starve_sat)
  );

  // Memory port mux; address parks on the last granted value when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = last_addr_q;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
      mem_addr  = cpu_addr;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q <= '0;
    end else if (cpu_gnt || dbg_gnt) begin
      last_addr_q <= mem_addr;
    end
  end

  // Two-stage read-return pipeline per port: grant -> data on bus -> rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_p1_q <= 1'b0;
      cpu_rv_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rd_p1_q <= 1'b0;
      dbg_rv_q    <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_rd_p1_q <= cpu_gnt & ~cpu_we;
      cpu_rv_q    <= cpu_rd_p1_q;
      dbg_rd_p1_q <= dbg_gnt;
      dbg_rv_q    <= dbg_rd_p1_q;
      if (cpu_rd_p1_q) cpu_rdata_q <= mem_rdata;
      if (dbg_rd_p1_q) dbg_rdata_q <= mem_rdata;
    end
  end

  // Read pulses are masked while reset is held so none escape mid-reset.
  assign cpu_rvalid = cpu_rv_q & ~rst;
  assign dbg_rvalid = dbg_rv_q & ~rst;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

  // Owner FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OWN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner FSM: next state follows this cycle's grant; unknown codes recover.
  always_comb begin
    state_d = OWN_IDLE;
    case (state_q)
      OWN_IDLE, OWN_CPU, OWN_DBG: begin
        if (cpu_gnt)      state_d = OWN_CPU;
        else if (dbg_gnt) state_d = OWN_DBG;
      end
      default: state_d = OWN_IDLE;
    endcase
  end

  assign owner = state_q;

endmodule
